id_exe_pipe_reg: RTL and testbench
==================================

// Module: id_exe_pipe_reg
// PURPOSE
//  Next-generation ID->EXE pipeline register. Parametrised widths and valid/ready handshake.
//  Two-entry skid buffer, so in_ready is registered.
//  Adds flush, bubble insertion (ctrl zeroed when invalid) and a bubble-cycle counter.
//  Sits between decode/register-read and the ALU/branch stage; hazard unit drives flush.
// PARAMETERS
//  DATA_W  32  width of rdata1/rdata2/imm
//  ADDR_W  5   register-file write address width
//  PC_W    32  width of PC and jump-concatenation target
//  CTRL_W  12  control bundle width (bit map in id_exe_pkg)
//  CNT_W   16  bubble counter width
// PORTS
//  clk        in   1       clock, all state on posedge
//  rst        in   1       synchronous, active-high reset
//  flush      in   1       squash all held entries (branch/jump taken)
//  in_valid   in   1       ID presents a decoded instruction
//  in_ready   out  1       stage can accept this cycle
//  in_rdata1  in   DATA_W  rs operand
//  in_rdata2  in   DATA_W  rt operand
//  in_imm     in   DATA_W  sign-extended immediate
//  in_waddr   in   ADDR_W  destination register
//  in_ctrl    in   CTRL_W  {opcode[2:0],alusrc,wen,memWrite,memRead,memToReg,branch,jal,jr,jump}
//  in_pc      in   PC_W    PC of instruction
//  in_conc    in   PC_W    jump target concatenation
//  out_valid  out  1       EXE holds a valid instruction
//  out_ready  in   1       EXE consumes this cycle
//  out_rdata1/out_rdata2/out_imm/out_waddr/out_ctrl/out_pc/out_conc  out  as inputs  registered payload
//  bubble_cnt out  CNT_W   cycles with out_valid=0 since reset
// BEHAVIOUR
//  Reset (rst=1 at posedge): all outputs 0; state EMPTY.
//   in_ready=0 while rst high, 1 the first cycle after.
//  Entries: MAIN (drives outputs) and SKID. States: EMPTY, ONE (MAIN valid), TWO (both valid).
//  accept = in_valid & in_ready; consume = out_valid & out_ready.
//  in_ready = ~skid_valid & ~rst (function of flops + rst only, never of out_ready).
//  EMPTY: accept -> ONE, MAIN<=in. Latency in->out is 1 cycle.
//  ONE:
//   - accept & consume -> ONE, MAIN<=in.
//   - accept & ~consume -> TWO, SKID<=in.
//   - consume only -> EMPTY.
//   - otherwise hold.
//  TWO: accept impossible (in_ready=0). consume -> ONE, MAIN<=SKID. Otherwise hold.
//  Throughput 1 instr/cycle while out_ready stays high; ordering strictly FIFO.
//  flush (priority over accept and consume, below rst): next state EMPTY.
//   - Both valids cleared; the in-cycle input is dropped.
//   - Data fields may keep stale values.
//  Bubble rule: out_ctrl == 0 whenever out_valid == 0 (wen/memWrite/branch never act on a bubble).
//   Payload data fields need not be zeroed.
//  bubble_cnt: +1 each non-reset cycle with out_valid=0; saturates at all-ones (no wrap).
//  Simultaneous flush+rst: rst wins (identical result except counter cleared).
//  Payload passes unmodified; no arithmetic on data.
// STRUCTURE
//  id_exe_pkg: CTRL_* bit-index localparams, CTRL_W, state encoding (EMPTY/ONE/TWO).
//  One sub-module: pipe_payload_slot
//   - One entry = valid flop + payload register.
//   - Ports: load, clear, d, q.
//   - Instantiated twice (MAIN, SKID).
//  Top holds the FSM, in_ready flop, ctrl gating and bubble counter.
// TESTING
//  1 Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, in_ready=0; bubble_cnt=0.
//  2 Streaming: 8 instrs, out_ready=1 -> each appears 1 cycle later, in order, no bubbles after first.
//  3 Backpressure: out_ready=0 for 3 cycles, in_valid=1 -> 2 accepted, in_ready=0;
//    release -> both drain in order, nothing lost or duplicated.
//  4 Flush in state TWO with wen=1, memWrite=1 pending -> next cycle out_valid=0, out_ctrl=0, in_ready=1.
//  5 Flush coincident with accept -> input dropped; next accepted instr emerges normally.
//  6 Idle 70000 cycles with CNT_W=16 -> bubble_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/id_exe_pkg.sv
// rtl/id_exe_pkg.sv - control-bundle bit map and occupancy encoding for the ID->EXE register
package id_exe_pkg;

  localparam int CTRL_BUNDLE_W   = 12;

  localparam int CTRL_JUMP       = 0;
  localparam int CTRL_JR         = 1;
  localparam int CTRL_JAL        = 2;
  localparam int CTRL_BRANCH     = 3;
  localparam int CTRL_MEMTOREG   = 4;
  localparam int CTRL_MEMREAD    = 5;
  localparam int CTRL_MEMWRITE   = 6;
  localparam int CTRL_WEN        = 7;
  localparam int CTRL_ALUSRC     = 8;
  localparam int CTRL_OPCODE_LSB = 9;
  localparam int CTRL_OPCODE_MSB = 11;

  // Encodes how many of the two entries (MAIN, SKID) hold a live instruction.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_payload_slot.sv
// rtl/pipe_payload_slot.sv - one pipeline entry: valid flag plus payload register
module pipe_payload_slot #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic [W-1:0] i_d,
  output logic         o_valid,
  output logic [W-1:0] o_q
);

  logic         r_valid;
  logic [W-1:0] r_q;

  // Clear only drops the valid flag; the payload keeps its stale value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_q     <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_q     <= i_d;
    end
  end

  assign o_valid = r_valid;
  assign o_q     = r_q;

endmodule

// File: rtl/id_exe_pipe_reg.sv
// rtl/id_exe_pipe_reg.sv - ID->EXE pipeline register with two-entry skid buffer, flush and bubble counter
module id_exe_pipe_reg
  import id_exe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PC_W   = 32,
  parameter int CTRL_W = id_exe_pkg::CTRL_BUNDLE_W,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_rdata1,
  input  logic [DATA_W-1:0] i_in_rdata2,
  input  logic [DATA_W-1:0] i_in_imm,
  input  logic [ADDR_W-1:0] i_in_waddr,
  input  logic [CTRL_W-1:0] i_in_ctrl,
  input  logic [PC_W-1:0]   i_in_pc,
  input  logic [PC_W-1:0]   i_in_conc,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_rdata1,
  output logic [DATA_W-1:0] o_out_rdata2,
  output logic [DATA_W-1:0] o_out_imm,
  output logic [ADDR_W-1:0] o_out_waddr,
  output logic [CTRL_W-1:0] o_out_ctrl,
  output logic [PC_W-1:0]   o_out_pc,
  output logic [PC_W-1:0]   o_out_conc,
  output logic [CNT_W-1:0]  o_bubble_cnt
);

  localparam int PAY_W = 3 * DATA_W + ADDR_W + CTRL_W + 2 * PC_W;

  pipe_state_e      r_state;
  pipe_state_e      w_state_nxt;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_bubble_cnt;

  logic             w_accept;
  logic             w_consume;
  logic             w_main_load;
  logic             w_main_clear;
  logic             w_skid_load;
  logic             w_skid_clear;
  logic             w_main_valid;
  logic             w_skid_valid;
  logic [PAY_W-1:0] w_in_pay;
  logic [PAY_W-1:0] w_main_d;
  logic [PAY_W-1:0] w_main_q;
  logic [PAY_W-1:0] w_skid_q;
  logic [CTRL_W-1:0] w_main_ctrl;

  assign w_in_pay = {i_in_rdata1, i_in_rdata2, i_in_imm, i_in_waddr,
                     i_in_ctrl, i_in_pc, i_in_conc};

  // Ready comes from a flop (mirrors "SKID empty") so it never depends on out_ready.
  assign o_in_ready = r_in_ready & ~i_rst;
  assign w_accept   = i_in_valid & o_in_ready;
  assign w_consume  = w_main_valid & i_out_ready;
  assign w_main_d   = (r_state == ST_TWO) ? w_skid_q : w_in_pay;

  always_comb begin
    w_state_nxt  = r_state;
    w_main_load  = 1'b0;
    w_main_clear = 1'b0;
    w_skid_load  = 1'b0;
    w_skid_clear = 1'b0;
    if (i_flush) begin
      w_state_nxt  = ST_EMPTY;
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_main_load = 1'b1;
            w_state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_consume) begin
            w_main_load = 1'b1;
          end else if (w_accept) begin
            w_skid_load = 1'b1;
            w_state_nxt = ST_TWO;
          end else if (w_consume) begin
            w_main_clear = 1'b1;
            w_state_nxt  = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_consume) begin
            w_main_load  = 1'b1;
            w_skid_clear = 1'b1;
            w_state_nxt  = ST_ONE;
          end
        end
        default: begin
          w_state_nxt  = ST_EMPTY;
          w_main_clear = 1'b1;
          w_skid_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_TWO);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bubble_cnt <= '0;
    end else if (!w_main_valid && (r_bubble_cnt != {CNT_W{1'b1}})) begin
      r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  pipe_payload_slot #(.W(PAY_W)) u_main (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_d     (w_main_d),
    .o_valid (w_main_valid),
    .o_q     (w_main_q)
  );

  pipe_payload_slot #(.W(PAY_W)) u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_d     (w_in_pay),
    .o_valid (w_skid_valid),
    .o_q     (w_skid_q)
  );

  assign {o_out_rdata1, o_out_rdata2, o_out_imm, o_out_waddr,
          w_main_ctrl, o_out_pc, o_out_conc} = w_main_q;

  // A bubble must never carry wen/memWrite/branch into EXE.
  assign o_out_ctrl   = w_main_ctrl & {CTRL_W{w_main_valid}};
  assign o_out_valid  = w_main_valid;
  assign o_bubble_cnt = r_bubble_cnt;

  logic w_unused;
  assign w_unused = w_skid_valid;

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// tb/tb_id_exe_pipe_reg.sv - randomized self-checking bench for id_exe_pipe_reg
module tb_id_exe_pipe_reg;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int PW = 32;
  localparam int CW = 12;
  localparam int NW = 16;
  localparam int TW = 3 * DW + AW + CW + 2 * PW;
  localparam int CTRL_LSB = 2 * PW;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [TW-1:0] in_bus;
  logic [TW-1:0] out_bus;
  logic          in_ready, out_valid;
  logic [DW-1:0] in_rd1, in_rd2, in_imm, out_rd1, out_rd2, out_imm;
  logic [AW-1:0] in_wa, out_wa;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [PW-1:0] in_pc, in_conc, out_pc, out_conc;
  logic [NW-1:0] bubble_cnt;

  logic [TW-1:0] mq[$];
  logic [NW-1:0] mcnt;
  int            errs = 0;
  int            checks = 0;

  always #5 clk = ~clk;

  assign {in_rd1, in_rd2, in_imm, in_wa, in_ctrl, in_pc, in_conc} = in_bus;
  assign out_bus = {out_rd1, out_rd2, out_imm, out_wa, out_ctrl, out_pc, out_conc};

  id_exe_pipe_reg #(.DATA_W(DW), .ADDR_W(AW), .PC_W(PW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_rdata1(in_rd1), .i_in_rdata2(in_rd2), .i_in_imm(in_imm),
    .i_in_waddr(in_wa), .i_in_ctrl(in_ctrl), .i_in_pc(in_pc), .i_in_conc(in_conc),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_rdata1(out_rd1), .o_out_rdata2(out_rd2), .o_out_imm(out_imm),
    .o_out_waddr(out_wa), .o_out_ctrl(out_ctrl), .o_out_pc(out_pc), .o_out_conc(out_conc),
    .o_bubble_cnt(bubble_cnt)
  );

  task automatic rand_payload();
    logic [191:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    in_bus = t[TW-1:0];
  endtask

  // Reference: a FIFO of at most two instructions plus a saturating idle counter.
  task automatic tick();
    bit acc, cons;
    acc  = in_valid && !rst && (mq.size() < 2);
    cons = (mq.size() > 0) && out_ready;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      mcnt = '0;
    end else begin
      if (mq.size() == 0 && mcnt != {NW{1'b1}}) mcnt = mcnt + 1'b1;
      if (flush) mq.delete();
      else begin
        if (cons) void'(mq.pop_front());
        if (acc) mq.push_back(in_bus);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    rand_payload();
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_ctrl !== '0) begin errs++; $display("FAIL reset_ctrl got=%h exp=0", out_ctrl); end
    checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (bubble_cnt !== '0) begin errs++; $display("FAIL reset_bubble got=%0d exp=0", bubble_cnt); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_streaming();
    logic [TW-1:0] sent;
    logic [NW-1:0] cnt_first;
    cnt_first = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_payload(); in_valid = 1'b1; sent = in_bus;
      tick();
      if (i == 0) cnt_first = bubble_cnt;
      checks++; if (out_valid !== 1'b1 || out_bus !== sent) begin
        errs++; $display("FAIL stream_%0d got=%b/%h exp=1/%h", i, out_valid, out_bus, sent);
      end
      checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL stream_ready_%0d got=%b exp=1", i, in_ready); end
    end
    checks++; if (bubble_cnt !== cnt_first) begin
      errs++; $display("FAIL stream_no_bubbles got=%0d exp=%0d", bubble_cnt, cnt_first);
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [TW-1:0] sent[3];
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_payload(); in_valid = 1'b1; sent[i] = in_bus;
      tick();
    end
    checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b1 || out_bus !== sent[0]) begin
      errs++; $display("FAIL bp_head got=%b/%h exp=1/%h", out_valid, out_bus, sent[0]);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_bus !== sent[1]) begin
      errs++; $display("FAIL bp_second got=%b/%h exp=1/%h", out_valid, out_bus, sent[1]);
    end
    checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_ready_back got=%b exp=1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush_two();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_payload();
      in_bus[CTRL_LSB + 7] = 1'b1;
      in_bus[CTRL_LSB + 6] = 1'b1;
      in_valid = 1'b1;
      tick();
    end
    checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL flush2_full got=%b exp=0", in_ready); end
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL flush2_valid got=%b exp=0", out_valid); end
    checks++; if (out_ctrl !== '0) begin errs++; $display("FAIL flush2_ctrl got=%h exp=0", out_ctrl); end
    checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL flush2_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_flush_accept();
    logic [TW-1:0] keep;
    out_ready = 1'b1;
    rand_payload(); in_valid = 1'b1;
    tick();
    rand_payload(); flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL flushacc_drop got=%b exp=0", out_valid); end
    rand_payload(); keep = in_bus;
    tick();
    checks++; if (out_valid !== 1'b1 || out_bus !== keep) begin
      errs++; $display("FAIL flushacc_next got=%b/%h exp=1/%h", out_valid, out_bus, keep);
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL flushacc_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 63) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rand_payload();
      tick();
      checks++; if (out_valid !== (mq.size() > 0)) begin
        errs++; $display("FAIL rnd_valid_%0d got=%b exp=%b", i, out_valid, mq.size() > 0);
      end
      checks++; if (in_ready !== (!rst && mq.size() < 2)) begin
        errs++; $display("FAIL rnd_ready_%0d got=%b exp=%b", i, in_ready, !rst && mq.size() < 2);
      end
      if (mq.size() > 0) begin
        checks++; if (out_bus !== mq[0]) begin
          errs++; $display("FAIL rnd_data_%0d got=%h exp=%h", i, out_bus, mq[0]);
        end
      end else begin
        checks++; if (out_ctrl !== '0) begin
          errs++; $display("FAIL rnd_bubble_ctrl_%0d got=%h exp=0", i, out_ctrl);
        end
      end
      checks++; if (bubble_cnt !== mcnt) begin
        errs++; $display("FAIL rnd_cnt_%0d got=%0d exp=%0d", i, bubble_cnt, mcnt);
      end
    end
    rst = 1'b0; flush = 1'b0;
  endtask

  task automatic test_saturate();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 65534; i++) tick();
    checks++; if (bubble_cnt !== 16'hFFFE) begin errs++; $display("FAIL sat_pre got=%h exp=fffe", bubble_cnt); end
    for (int i = 0; i < 70000 - 65534; i++) tick();
    checks++; if (bubble_cnt !== 16'hFFFF) begin errs++; $display("FAIL sat_hold got=%h exp=ffff", bubble_cnt); end
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL sat_valid got=%b exp=0", out_valid); end
  endtask

  initial begin
    mq.delete();
    mcnt = '0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_bus = '0;
    #2;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_two();
    test_flush_accept();
    test_random();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
